jacobi_rot_accum: RTL

//  Downstream consumer of mux2's I1..I9 in the Jacobi eigen-solver: computes V = (I x R) / SCALE.
//  I is the current accumulated eigenvector matrix; R is the Jacobi rotation for this iteration.
//  R entries are fixed-point with SCALE=100 representing 1.0, matching mux2's identity of 100.
//  The result v1..v9 feeds back to mux2's v inputs for the next iteration.

---
 rtl/jacobi_rot_accum_pkg.sv | 29 ++
 rtl/jacobi_rot_accum_if.sv | 23 ++
 rtl/jacobi_rot_accum_sat_scale_div.sv | 27 ++
 rtl/jacobi_rot_accum.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/jacobi_rot_accum_pkg.sv
// Shared types and constants for the Jacobi rotation accumulator (V = I x R / SCALE).
// Element width, fixed-point unit, accumulator width, FSM encoding, saturation limits.
// Also holds the row-major index helper used by the operand muxes.
package jacobi_rot_accum_pkg;

  localparam int DATA_W = 21;
  localparam int SCALE  = 100;
  localparam int ACC_W  = 2 * DATA_W + 2;
  localparam int NELEM  = 9;

  typedef logic signed [DATA_W-1:0]   elem_t;
  typedef logic signed [2*DATA_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam elem_t DATA_MAX = elem_t'((2 ** (DATA_W - 1)) - 1);
  localparam elem_t DATA_MIN = elem_t'(-(2 ** (DATA_W - 1)));

  // Row-major flat index of a 3x3 element: 3*r + c.
  function automatic logic [3:0] rm_idx(input logic [1:0] r, input logic [1:0] c);
    return {1'b0, r, 1'b0} + {2'b00, r} + {2'b00, c};
  endfunction

endpackage

// File: rtl/jacobi_rot_accum_if.sv
// Bus between the matrix source and the rotation accumulator.
// Carries start request, both operand matrices (row-major), busy/done status and results.
// The driver side owns start and operands; the accumulator owns busy, done and v.
interface jacobi_rot_accum_if import jacobi_rot_accum_pkg::*; ();

  logic  start;
  elem_t i_mat [NELEM];
  elem_t r_mat [NELEM];
  logic  busy;
  logic  done;
  elem_t v     [NELEM];

  modport master (
    output start, i_mat, r_mat,
    input  busy, done, v
  );

  modport slave (
    input  start, i_mat, r_mat,
    output busy, done, v
  );

endinterface

// File: rtl/jacobi_rot_accum_sat_scale_div.sv
// Scales an accumulated dot product back to element range: acc / SCALE, then saturate.
// Purely combinational; division truncates toward zero (signed).
// No handshake; output follows input.
module jacobi_rot_accum_sat_scale_div import jacobi_rot_accum_pkg::*; (
  input  acc_t  acc_i,
  output elem_t q_o
);

  localparam acc_t SCALE_A = acc_t'(SCALE);
  localparam acc_t MAX_A   = acc_t'(DATA_MAX);
  localparam acc_t MIN_A   = acc_t'(DATA_MIN);

  acc_t quot;

  // Signed divide, then clamp the quotient into the element range.
  always_comb begin
    quot = acc_i / SCALE_A;
    if (quot > MAX_A) begin
      q_o = DATA_MAX;
    end else if (quot < MIN_A) begin
      q_o = DATA_MIN;
    end else begin
      q_o = elem_t'(quot);
    end
  end

endmodule

// File: rtl/jacobi_rot_accum.sv
// Computes V = (I x R) / SCALE with one shared multiplier, three MAC cycles per element.
// Latency: start accepted at t0, element k written at t0+4(k+1), done pulses at t0+36.
// start is only sampled while idle; requests during a run are dropped, not queued.
module jacobi_rot_accum import jacobi_rot_accum_pkg::*; (
  input logic               clk,
  input logic               rst,
  jacobi_rot_accum_if.slave bus
);

  state_t      state_q, state_d;
  logic [3:0]  k_q, k_d;
  logic [1:0]  j_q, j_d;
  logic [1:0]  row_q, row_d;
  logic [1:0]  col_q, col_d;
  acc_t        acc_q, acc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  elem_t       v_q [NELEM];
  elem_t       v_d [NELEM];
  elem_t       opi_q [NELEM];
  elem_t       opr_q [NELEM];
  logic        load_ops;
  elem_t       mul_a, mul_b;
  prod_t       prod;
  acc_t        prod_ext;
  elem_t       q_sat;

  // Operand muxes pick I[row][j] and R[j][col]; single shared multiplier.
  always_comb begin
    mul_a    = opi_q[rm_idx(row_q, j_q)];
    mul_b    = opr_q[rm_idx(j_q, col_q)];
    prod     = prod_t'(mul_a) * prod_t'(mul_b);
    prod_ext = acc_t'(prod);
  end

  jacobi_rot_accum_sat_scale_div u_div (
    .acc_i (acc_q),
    .q_o   (q_sat)
  );

  // Next-state and datapath control for IDLE -> MAC x3 -> WRITE per element.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    j_d      = j_q;
    row_d    = row_q;
    col_d    = col_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    v_d      = v_q;
    load_ops = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          load_ops = 1'b1;
          busy_d   = 1'b1;
          k_d      = 4'd0;
          j_d      = 2'd0;
          row_d    = 2'd0;
          col_d    = 2'd0;
          state_d  = ST_MAC;
        end
      end
      ST_MAC: begin
        // First term overwrites acc so no separate clear cycle is needed.
        if (j_q == 2'd0) begin
          acc_d = prod_ext;
        end else begin
          acc_d = acc_q + prod_ext;
        end
        if (j_q == 2'd2) begin
          state_d = ST_WRITE;
        end else begin
          j_d = j_q + 2'd1;
        end
      end
      ST_WRITE: begin
        v_d[k_q] = q_sat;
        j_d      = 2'd0;
        if (k_q == 4'd8) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          k_d     = 4'd0;
          row_d   = 2'd0;
          col_d   = 2'd0;
          state_d = ST_IDLE;
        end else begin
          k_d = k_q + 4'd1;
          if (col_q == 2'd2) begin
            col_d = 2'd0;
            row_d = row_q + 2'd1;
          end else begin
            col_d = col_q + 2'd1;
          end
          state_d = ST_MAC;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters, accumulator and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= 4'd0;
      j_q     <= 2'd0;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NELEM; i++) begin
        v_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      j_q     <= j_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      v_q     <= v_d;
    end
  end

  // Operand snapshot: the source may change I/R while a run is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NELEM; i++) begin
        opi_q[i] <= '0;
        opr_q[i] <= '0;
      end
    end else if (load_ops) begin
      opi_q <= bus.i_mat;
      opr_q <= bus.r_mat;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.v    = v_q;

endmodule
